// File: rtl/game_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : game_pkg
// Description : Shared definitions for the combat arbiter: FSM state
//               encoding, player identifiers, default game constants and a
//               saturating 8-bit subtract helper.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
package game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_APPLY     = 2'd1,
    ST_GAME_OVER = 2'd2
  } state_t;

  localparam logic c_P1 = 1'b0;
  localparam logic c_P2 = 1'b1;

  localparam int c_MAX_HEALTH_DEFAULT  = 15;
  localparam int c_MAX_SHIELD_DEFAULT  = 15;
  localparam int c_DAMAGE_DEFAULT      = 3;
  localparam int c_SHIELD_COST_DEFAULT = 2;

  // a - b, clamped at zero.
  function automatic logic [7:0] sat_sub(input logic [7:0] a, input logic [7:0] b);
    return (a > b) ? (a - b) : 8'd0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/combat_arbiter_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : combat_arbiter_if
// Description : Bundle of player-side controls and HUD-side results of the
//               combat arbiter.
//   master : drives round_start, attack requests, shield buttons, collision;
//            observes health/shield, event pulses, game_over, winner.
//   slave  : the arbiter side (mirror directions).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
interface combat_arbiter_if;
  logic       round_start;
  logic       p1_attack_request;
  logic       p2_attack_request;
  logic       p1_shield_btn;
  logic       p2_shield_btn;
  logic       collision;
  logic [7:0] p1_health;
  logic [7:0] p2_health;
  logic [7:0] p1_shield;
  logic [7:0] p2_shield;
  logic       hit_event;
  logic       block_event;
  logic       miss_event;
  logic       event_attacker;
  logic       game_over;
  logic       winner;

  modport master (
    output round_start, p1_attack_request, p2_attack_request,
           p1_shield_btn, p2_shield_btn, collision,
    input  p1_health, p2_health, p1_shield, p2_shield,
           hit_event, block_event, miss_event, event_attacker,
           game_over, winner
  );

  modport slave (
    input  round_start, p1_attack_request, p2_attack_request,
           p1_shield_btn, p2_shield_btn, collision,
    output p1_health, p2_health, p1_shield, p2_shield,
           hit_event, block_event, miss_event, event_attacker,
           game_over, winner
  );
endinterface
`default_nettype wire

// File: rtl/attack_cooldown.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : attack_cooldown
// Description : Per-player attack latch and lockout counter. Holds at most
//               one pending request; requests arriving while pending, while
//               cooling down or while disabled are dropped.
// Ports       :
//   clk        in  system clock
//   reset      in  synchronous active-high reset
//   i_clear    in  round restart: clears latch and counter
//   i_request  in  attack request (pulse or level)
//   i_enable   in  0 flushes the latch and blocks new requests
//   i_service  in  attack is being resolved: clear latch, load cooldown
//   o_pending  out a request is waiting for service
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module attack_cooldown #(
  parameter int COOLDOWN_CYCLES = 25_000_000
) (
  input  wire  clk,
  input  wire  reset,
  input  wire  i_clear,
  input  wire  i_request,
  input  wire  i_enable,
  input  wire  i_service,
  output logic o_pending
);

  localparam int              c_CW   = $clog2(COOLDOWN_CYCLES + 1);
  localparam logic [c_CW-1:0] c_LOAD = c_CW'(COOLDOWN_CYCLES);

  logic [c_CW-1:0] r_count;
  logic            r_pending;
  logic            w_ready;

  assign w_ready   = (r_count == '0);
  assign o_pending = r_pending;

  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_pending <= 1'b0;
      r_count   <= '0;
    end else begin
      if (i_service)
        r_count <= c_LOAD;
      else if (!w_ready)
        r_count <= r_count - c_CW'(1);

      if (!i_enable || i_service)
        r_pending <= 1'b0;
      else if (i_request && !r_pending && w_ready)
        r_pending <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/combat_arbiter.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : combat_arbiter
// Description : Resolves attacks between two players. Latches requests,
//               grants one per two-cycle service slot with round-robin
//               priority, applies hit/block/miss outcomes to the health and
//               shield registers it owns, regenerates shields and detects
//               the end of a round.
// Ports       :
//   clk    in  system clock
//   reset  in  synchronous active-high reset
//   bus    slave side of combat_arbiter_if (controls in, HUD state out)
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module combat_arbiter
  import game_pkg::*;
#(
  parameter int MAX_HEALTH      = c_MAX_HEALTH_DEFAULT,
  parameter int MAX_SHIELD      = c_MAX_SHIELD_DEFAULT,
  parameter int DAMAGE          = c_DAMAGE_DEFAULT,
  parameter int SHIELD_COST     = c_SHIELD_COST_DEFAULT,
  parameter int COOLDOWN_CYCLES = 25_000_000,
  parameter int REGEN_CYCLES    = 50_000_000
) (
  input wire              clk,
  input wire              reset,
  combat_arbiter_if.slave bus
);

  localparam logic [7:0] c_MAXH = 8'(MAX_HEALTH);
  localparam logic [7:0] c_MAXS = 8'(MAX_SHIELD);
  localparam logic [7:0] c_DMG  = 8'(DAMAGE);
  localparam logic [7:0] c_COST = 8'(SHIELD_COST);

  localparam int              c_RW         = (REGEN_CYCLES > 1) ? $clog2(REGEN_CYCLES) : 1;
  localparam logic [c_RW-1:0] c_REGEN_LAST = c_RW'(REGEN_CYCLES - 1);

  state_t          r_state;
  logic            r_prio;
  logic            r_attacker;
  logic [7:0]      r_p1_health;
  logic [7:0]      r_p2_health;
  logic [7:0]      r_p1_shield;
  logic [7:0]      r_p2_shield;
  logic            r_hit;
  logic            r_block;
  logic            r_miss;
  logic            r_ev_att;
  logic            r_game_over;
  logic            r_winner;
  logic [c_RW-1:0] r_regen;

  logic       w_p1_pending;
  logic       w_p2_pending;
  logic       w_enable;
  logic       w_apply;
  logic       w_grant;
  logic       w_tick;
  logic [7:0] w_def_health;
  logic [7:0] w_def_shield;
  logic       w_def_btn;
  logic       w_blocked;
  logic [7:0] w_def_health_nxt;
  logic [7:0] w_def_shield_nxt;

  assign w_enable = (r_state != ST_GAME_OVER);
  assign w_apply  = (r_state == ST_APPLY);
  assign w_tick   = (r_regen == c_REGEN_LAST);

  // With both pending the priority holder wins; otherwise whoever is pending
  // (a lone P2 request yields 1, a lone P1 request yields 0).
  assign w_grant = (w_p1_pending && w_p2_pending) ? r_prio : w_p2_pending;

  // Defender view during APPLY; r_attacker holds the granted player.
  assign w_def_health     = (r_attacker == c_P1) ? r_p2_health : r_p1_health;
  assign w_def_shield     = (r_attacker == c_P1) ? r_p2_shield : r_p1_shield;
  assign w_def_btn        = (r_attacker == c_P1) ? bus.p2_shield_btn : bus.p1_shield_btn;
  assign w_blocked        = bus.collision && w_def_btn && (w_def_shield >= c_COST);
  assign w_def_health_nxt = sat_sub(w_def_health, c_DMG);
  assign w_def_shield_nxt = sat_sub(w_def_shield, c_COST);

  attack_cooldown #(.COOLDOWN_CYCLES(COOLDOWN_CYCLES)) u_p1_cd (
    .clk       (clk),
    .reset     (reset),
    .i_clear   (bus.round_start),
    .i_request (bus.p1_attack_request),
    .i_enable  (w_enable),
    .i_service (w_apply && (r_attacker == c_P1)),
    .o_pending (w_p1_pending)
  );

  attack_cooldown #(.COOLDOWN_CYCLES(COOLDOWN_CYCLES)) u_p2_cd (
    .clk       (clk),
    .reset     (reset),
    .i_clear   (bus.round_start),
    .i_request (bus.p2_attack_request),
    .i_enable  (w_enable),
    .i_service (w_apply && (r_attacker == c_P2)),
    .o_pending (w_p2_pending)
  );

  always_ff @(posedge clk) begin
    if (reset || bus.round_start) begin
      r_state     <= ST_IDLE;
      r_prio      <= c_P1;
      r_attacker  <= c_P1;
      r_p1_health <= c_MAXH;
      r_p2_health <= c_MAXH;
      r_p1_shield <= c_MAXS;
      r_p2_shield <= c_MAXS;
      r_hit       <= 1'b0;
      r_block     <= 1'b0;
      r_miss      <= 1'b0;
      r_ev_att    <= 1'b0;
      r_game_over <= 1'b0;
      r_winner    <= 1'b0;
      r_regen     <= '0;
    end else begin
      r_hit   <= 1'b0;
      r_block <= 1'b0;
      r_miss  <= 1'b0;
      r_regen <= w_tick ? '0 : (r_regen + c_RW'(1));

      // Regen first; a block in APPLY below reassigns the defender shield,
      // so the block wins over a coincident tick.
      if (w_enable && w_tick) begin
        if (!bus.p1_shield_btn && (r_p1_shield < c_MAXS))
          r_p1_shield <= r_p1_shield + 8'd1;
        if (!bus.p2_shield_btn && (r_p2_shield < c_MAXS))
          r_p2_shield <= r_p2_shield + 8'd1;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_p1_pending || w_p2_pending) begin
            r_attacker <= w_grant;
            r_prio     <= ~w_grant;
            r_state    <= ST_APPLY;
          end
        end

        ST_APPLY: begin
          r_ev_att <= r_attacker;
          if (!bus.collision) begin
            r_miss <= 1'b1;
          end else if (w_blocked) begin
            r_block <= 1'b1;
            if (r_attacker == c_P1)
              r_p2_shield <= w_def_shield_nxt;
            else
              r_p1_shield <= w_def_shield_nxt;
          end else begin
            r_hit <= 1'b1;
            if (r_attacker == c_P1)
              r_p2_health <= w_def_health_nxt;
            else
              r_p1_health <= w_def_health_nxt;
          end

          if (bus.collision && !w_blocked && (w_def_health_nxt == 8'd0)) begin
            r_state     <= ST_GAME_OVER;
            r_game_over <= 1'b1;
            r_winner    <= r_attacker;
          end else begin
            r_state <= ST_IDLE;
          end
        end

        ST_GAME_OVER: begin
          r_state <= ST_GAME_OVER;
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.p1_health      = r_p1_health;
  assign bus.p2_health      = r_p2_health;
  assign bus.p1_shield      = r_p1_shield;
  assign bus.p2_shield      = r_p2_shield;
  assign bus.hit_event      = r_hit;
  assign bus.block_event    = r_block;
  assign bus.miss_event     = r_miss;
  assign bus.event_attacker = r_ev_att;
  assign bus.game_over      = r_game_over;
  assign bus.winner         = r_winner;

endmodule
`default_nettype wire

// File: tb/tb_combat_arbiter.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tb_combat_arbiter
// Description : Directed self-checking bench for combat_arbiter with
//               COOLDOWN_CYCLES=8 and REGEN_CYCLES=16.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_combat_arbiter;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_hits;

  combat_arbiter_if bus ();

  combat_arbiter #(
    .COOLDOWN_CYCLES (8),
    .REGEN_CYCLES    (16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  // Request at edge k, grant at k+1, result visible after k+2 (on return).
  task automatic fire(input logic p1, input logic p2);
    bus.p1_attack_request = p1;
    bus.p2_attack_request = p2;
    step();
    bus.p1_attack_request = 1'b0;
    bus.p2_attack_request = 1'b0;
    step();
    step();
  endtask

  initial begin
    reset                 = 1'b1;
    bus.round_start       = 1'b0;
    bus.p1_attack_request = 1'b0;
    bus.p2_attack_request = 1'b0;
    bus.p1_shield_btn     = 1'b0;
    bus.p2_shield_btn     = 1'b0;
    bus.collision         = 1'b1;
    step();
    step();

    // Reset state
    check("rst_p1_health", bus.p1_health, 15);
    check("rst_p2_health", bus.p2_health, 15);
    check("rst_p1_shield", bus.p1_shield, 15);
    check("rst_p2_shield", bus.p2_shield, 15);
    check("rst_events", {bus.hit_event, bus.block_event, bus.miss_event}, 0);
    check("rst_game_over", {bus.game_over, bus.winner}, 0);
    reset = 1'b0;

    // Single P1 hit with latency check
    bus.p1_attack_request = 1'b1;
    step();
    bus.p1_attack_request = 1'b0;
    step();
    check("lat_no_event_k1", bus.hit_event, 0);
    check("lat_health_k1", bus.p2_health, 15);
    step();
    check("hit_p2_health", bus.p2_health, 12);
    check("hit_event", {bus.hit_event, bus.block_event, bus.miss_event}, 3'b100);
    check("hit_attacker", bus.event_attacker, 0);
    step();
    check("hit_pulse_len", bus.hit_event, 0);
    idle(8);

    // Simultaneous pair: P1 first, P2 two cycles later, priority back to P1
    do_reset();
    fire(1'b1, 1'b1);
    check("pair1_p2_health", bus.p2_health, 12);
    check("pair1_p1_health", bus.p1_health, 15);
    check("pair1_attacker", bus.event_attacker, 0);
    step();
    check("pair_gap", bus.hit_event, 0);
    step();
    check("pair2_p1_health", bus.p1_health, 12);
    check("pair2_hit", bus.hit_event, 1);
    check("pair2_attacker", bus.event_attacker, 1);
    idle(10);
    fire(1'b1, 1'b1);
    check("pair3_p1_first", bus.event_attacker, 0);
    check("pair3_p2_health", bus.p2_health, 9);
    step();
    step();
    check("pair4_attacker", bus.event_attacker, 1);
    check("pair4_p1_health", bus.p1_health, 9);
    idle(10);

    // Miss
    do_reset();
    bus.collision = 1'b0;
    fire(1'b1, 1'b0);
    check("miss_events", {bus.hit_event, bus.block_event, bus.miss_event}, 3'b001);
    check("miss_p2_health", bus.p2_health, 15);
    bus.collision = 1'b1;
    step();
    idle(8);

    // Block, then drain P2 shield to 1 and hit through it
    do_reset();
    bus.p2_shield_btn = 1'b1;
    fire(1'b1, 1'b0);
    check("blk_events", {bus.hit_event, bus.block_event, bus.miss_event}, 3'b010);
    check("blk_p2_shield", bus.p2_shield, 13);
    check("blk_p2_health", bus.p2_health, 15);
    step();
    idle(8);
    for (int i = 0; i < 6; i++) begin
      fire(1'b1, 1'b0);
      step();
      idle(8);
    end
    check("blk_drained", bus.p2_shield, 1);
    fire(1'b1, 1'b0);
    check("lowshield_hit", {bus.hit_event, bus.block_event}, 2'b10);
    check("lowshield_health", bus.p2_health, 12);
    check("lowshield_shield", bus.p2_shield, 1);
    bus.p2_shield_btn = 1'b0;

    // Request held: grants at latch edges 0, 11, 22 only
    do_reset();
    n_hits = 0;
    bus.p1_attack_request = 1'b1;
    for (int i = 0; i < 24; i++) begin
      step();
      if (bus.hit_event) n_hits++;
    end
    bus.p1_attack_request = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (bus.hit_event) n_hits++;
    end
    check("burst_grants", n_hits, 3);
    check("burst_p2_health", bus.p2_health, 6);

    // Game over after five hits
    do_reset();
    for (int i = 0; i < 4; i++) begin
      fire(1'b1, 1'b0);
      step();
      idle(8);
    end
    check("go_pre_health", bus.p2_health, 3);
    fire(1'b1, 1'b0);
    check("go_p2_health", bus.p2_health, 0);
    check("go_flag", bus.game_over, 1);
    check("go_winner", bus.winner, 0);
    bus.p1_attack_request = 1'b1;
    bus.p2_attack_request = 1'b1;
    idle(20);
    bus.p1_attack_request = 1'b0;
    bus.p2_attack_request = 1'b0;
    idle(4);
    check("go_frozen_p1", bus.p1_health, 15);
    check("go_frozen_events", {bus.hit_event, bus.block_event, bus.miss_event}, 0);
    check("go_still_over", bus.game_over, 1);
    bus.round_start = 1'b1;
    step();
    bus.round_start = 1'b0;
    check("rs_p2_health", bus.p2_health, 15);
    check("rs_p2_shield", bus.p2_shield, 15);
    check("rs_game_over", bus.game_over, 0);
    fire(1'b1, 1'b0);
    check("rs_cooldown_cleared", bus.p2_health, 12);
    step();
    idle(8);

    // Shield drain by P2 blocks, regen, and regen blocked by holding
    do_reset();
    bus.p1_shield_btn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      fire(1'b0, 1'b1);
      step();
      idle(8);
    end
    check("regen_drained", bus.p1_shield, 9);
    bus.p1_shield_btn = 1'b0;
    idle(64);
    check("regen_up", bus.p1_shield, 13);
    check("regen_cap", bus.p2_shield, 15);
    bus.p1_shield_btn = 1'b1;
    idle(32);
    check("regen_held", bus.p1_shield, 13);
    bus.p1_shield_btn = 1'b0;

    // Reset during APPLY
    do_reset();
    bus.p1_attack_request = 1'b1;
    step();
    bus.p1_attack_request = 1'b0;
    step();
    reset = 1'b1;
    step();
    check("midrst_health", bus.p2_health, 15);
    check("midrst_events", {bus.hit_event, bus.block_event, bus.miss_event}, 0);
    check("midrst_shield", bus.p1_shield, 15);
    reset = 1'b0;
    idle(3);
    check("midrst_flushed", bus.p2_health, 15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
